color_mapping_mul_arbiter: RTL
==============================

Name: color_mapping_mul_arbiter

Overview:
- Shares one signed-9 × unsigned-42 → 50-bit multiplier among NUM_REQ requesters in the color_mapping datapath (per-channel R/G/B gain scaling of acoustic-intensity values).
- Arbitration is round-robin with per-requester valid/ready on the request side.
- A two-stage pipeline computes the product and returns it on a single tagged response channel with backpressure.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- A_WIDTH, 9, signed multiplicand width.
- B_WIDTH, 42, unsigned multiplicand width.
- P_WIDTH, 50, product width; the low P_WIDTH bits of the exact product are kept.
- TAG_WIDTH, 8, opaque per-request tag returned with the result.

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  packed signed operands; requester i at slice [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed unsigned operands, same packing.
- req_tag  in  NUM_REQ*TAG_WIDTH  packed tags, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_data  out  P_WIDTH  product.
- rsp_id  out  $clog2(NUM_REQ)  index of the originating requester.
- rsp_tag  out  TAG_WIDTH  tag of the originating request.
- busy  out  1  any pipeline stage holds valid data.
- accept_cnt  out  32  free-running count of accepted requests; wraps at 2^32.

Behaviour:
- Reset state, entered asynchronously:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0.
  - busy=0, accept_cnt=0, req_ready=0.
  - Round-robin pointer=0; both stage valid bits cleared.
- Reset asserted mid-operation discards in-flight results. No response is produced for them.
- Pipeline:
  - S1 holds the captured operands, id and tag.
  - S2 holds the product registered on rsp_*.
  - advance = !s2_valid || rsp_ready.
  - S1→S2 moves when advance is true.
  - S1 can accept when !s1_valid || advance. This gives full throughput of one result per cycle with no bubbles.
- Arbitration (combinational, in the same cycle):
  - When S1 can accept, grant the first i with req_valid[i]=1, searching from the pointer and wrapping modulo NUM_REQ.
  - req_ready[grant]=1; all other bits are 0.
  - On a grant, pointer ← grant+1 mod NUM_REQ. With no grant, the pointer holds.
  - req_ready is never asserted while S1 cannot accept.
- Handshake rules:
  - A request transfers when req_valid[i] && req_ready[i].
  - Requesters must hold operands stable until the transfer; the block does not register unaccepted requests.
  - A response transfers when rsp_valid && rsp_ready.
  - While rsp_valid && !rsp_ready, rsp_* hold stable.
- Latency: a transfer in cycle N gives rsp_valid in cycle N+2 if there is no backpressure.
- Arithmetic:
  - product = signed(a) × signed({1'b0,b}), exact width A_WIDTH+B_WIDTH+1.
  - rsp_data = product[P_WIDTH-1:0]. Overflow wraps silently; there is no saturation.
- Pipeline-control states, from (s1_valid, s2_valid):
  - EMPTY: 0,0.
  - ONE: 1,0 or 0,1.
  - FULL: 1,1.
  - In FULL with rsp_ready=0, no grant is issued; this is the full condition.
- Simultaneous events:
  - A response handoff and a new accept in the same cycle are both honoured.
  - A stalled S2 together with an empty S1 still allows one accept.
- busy = s1_valid || s2_valid.
- accept_cnt increments once per request transfer.

Decomposition:
- Package color_mapping_pkg:
  - Width constants CM_A_W=9, CM_B_W=42, CM_P_W=50.
  - Typedef cm_mul_req_t {a, b, tag}.
  - Function for requester-index width.
- Sub-module cm_rr_arbiter (NUM_REQ): inputs req_valid, enable; outputs one-hot grant, grant index; owns the pointer register.
- The multiply is an inline combinational expression between S1 and S2; no separate core is instantiated.

Test Plan:
- Basic product: req0 sends a=9'h1FD (−3), b=5, tag=8'h11, with rsp_ready=1. Expect req_ready[0] in the same cycle. Two cycles later expect rsp_data=50'h3FFFFFFFFFFF1, rsp_id=0, rsp_tag=8'h11.
- Width extremes:
  - a=255, b=2^42−1 → 50'h3FBFFFFFFFF01.
  - a=−256, b=2^42−1 → 50'h100 (wrapped).
  - a=0, any b → 0.
- Round-robin fairness: all 3 requesters held valid for 9 cycles with rsp_ready=1. Expect grants 0,1,2,0,1,2,0,1,2, one rsp per cycle, and accept_cnt=9.
- Backpressure: hold rsp_ready=0 after 2 accepts.
  - Expect req_ready all 0 and rsp_* stable.
  - When rsp_ready rises, expect 2 responses over 2 cycles in order, with no drops or duplicates.
- Sparse grant and pointer: with the pointer at 1, only req0 is valid. Expect grant 0 and pointer→1. Then req1 and req2 both valid → expect grant 1.
- Reset mid-flight: assert ap_rst_n=0 asynchronously with S1 and S2 full.
  - Expect rsp_valid=0, busy=0, accept_cnt=0 immediately.
  - After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/color_mapping_pkg.sv
// Shared widths, request type and helpers for the color_mapping gain multiplier.
package color_mapping_pkg;

  localparam int CM_A_W   = 9;
  localparam int CM_B_W   = 42;
  localparam int CM_P_W   = 50;
  localparam int CM_TAG_W = 8;

  typedef struct packed {
    logic signed [CM_A_W-1:0]   a;
    logic        [CM_B_W-1:0]   b;
    logic        [CM_TAG_W-1:0] tag;
  } cm_mul_req_t;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } cm_pipe_e;

  // Requester-index width, never narrower than one bit.
  function automatic int cm_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req_valid, searching from a rotating pointer.
// Latency: combinational grant; pointer updates on the clock edge after a grant.
// Backpressure: enable=0 suppresses every grant and freezes the pointer.
module cm_rr_arbiter
  import color_mapping_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = cm_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;
  logic            found;

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (enable && !found && req_valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  // The winner becomes lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/color_mapping_mul_arbiter.sv
// Shared signed x unsigned gain multiplier for NUM_REQ requesters, round-robin arbitrated.
// Latency: 2 cycles from request transfer to rsp_valid; one result per cycle sustained.
// Backpressure: rsp_ready low stalls S2; S1 fills once more, then req_ready drops to 0.
module color_mapping_mul_arbiter
  import color_mapping_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int A_WIDTH   = CM_A_W,
  parameter int B_WIDTH   = CM_B_W,
  parameter int P_WIDTH   = CM_P_W,
  parameter int TAG_WIDTH = CM_TAG_W,
  parameter int ID_W      = cm_idx_w(NUM_REQ)
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]     req_b,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [P_WIDTH-1:0]             rsp_data,
  output logic [ID_W-1:0]                rsp_id,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic                           busy,
  output logic [31:0]                    accept_cnt
);

  typedef struct packed {
    logic signed [A_WIDTH-1:0]   a;
    logic        [B_WIDTH-1:0]   b;
    logic        [TAG_WIDTH-1:0] tag;
    logic        [ID_W-1:0]      id;
  } s1_t;

  s1_t                s1_q;
  s1_t                sel;
  logic               s1_valid;
  logic               s2_valid;
  logic               advance;
  logic               s1_can;
  logic               accept;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  cm_pipe_e           pipe_state;
  logic [P_WIDTH-1:0] a_ext;
  logic [P_WIDTH-1:0] b_ext;
  logic [P_WIDTH-1:0] prod;

  always_comb begin
    pipe_state = PIPE_EMPTY;
    if (s1_valid && s2_valid)      pipe_state = PIPE_FULL;
    else if (s1_valid || s2_valid) pipe_state = PIPE_ONE;
  end

  assign advance = !s2_valid || rsp_ready;
  assign s1_can  = !(pipe_state == PIPE_FULL && !rsp_ready);
  // Grants are held off while reset is asserted so req_ready reads 0 in reset.
  assign arb_en  = s1_can && ap_rst_n;
  assign accept  = |grant;
  assign busy    = (pipe_state != PIPE_EMPTY);

  assign req_ready = grant;
  assign rsp_valid = s2_valid;

  cm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .req_valid (req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.a   = req_a[i*A_WIDTH +: A_WIDTH];
        sel.b   = req_b[i*B_WIDTH +: B_WIDTH];
        sel.tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    sel.id = grant_idx;
  end

  // Only the low P_WIDTH bits are kept, so operands are extended straight to P_WIDTH.
  assign a_ext = P_WIDTH'($signed(s1_q.a));
  assign b_ext = P_WIDTH'({1'b0, s1_q.b});
  assign prod  = a_ext * b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s2_valid   <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      accept_cnt <= '0;
    end else begin
      if (accept) accept_cnt <= accept_cnt + 32'd1;
      if (s1_can) begin
        s1_valid <= accept;
        if (accept) s1_q <= sel;
      end
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data <= prod;
          rsp_id   <= s1_q.id;
          rsp_tag  <= s1_q.tag;
        end
      end
    end
  end

endmodule
